// File: rtl/uart_fifo_device_pkg.sv
// Shared definitions for the FIFO-buffered UART device:
// register map, parity codes, flag/error/config bit positions.
package uart_fifo_device_pkg;

    localparam logic [3:0] REG_ID     = 4'd0;
    localparam logic [3:0] REG_INFO   = 4'd1;
    localparam logic [3:0] REG_DIV    = 4'd2;
    localparam logic [3:0] REG_TXDATA = 4'd3;
    localparam logic [3:0] REG_RXDATA = 4'd4;
    localparam logic [3:0] REG_CONFIG = 4'd5;
    localparam logic [3:0] REG_ERR    = 4'd6;
    localparam logic [3:0] REG_COUNTS = 4'd7;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam int FLAG_TX_NOT_FULL  = 0;
    localparam int FLAG_RX_NOT_EMPTY = 1;
    localparam int FLAG_TX_BUSY      = 2;
    localparam int FLAG_ERROR        = 3;

    localparam int ERR_TX_OVF = 0;
    localparam int ERR_RX_OVR = 1;
    localparam int ERR_PARITY = 2;
    localparam int ERR_FRAME  = 3;

    localparam int CFG_TWO_STOP = 2;
    localparam int CFG_IRQ_RX   = 3;
    localparam int CFG_IRQ_TX   = 4;
    localparam int CFG_IRQ_ERR  = 5;

    localparam logic [3:0] GENERATION = 4'h2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP1,
        TX_STOP2
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Bit that makes the frame's total count of ones even/odd.
    function automatic logic parity_bit(input logic [1:0] mode,
                                        input logic [7:0] d);
        return (mode == PAR_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_fifo_device_sync_fifo.sv
// Synchronous FIFO with occupancy count; full pushes and
// empty pops are ignored. DEPTH must be a power of 2 (2..256).
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [8:0]       count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [8:0] DEPTH_C = 9'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == 9'd0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage array, written only on an accepted push.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally; count moves by push minus pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 9'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {8'd0, do_push} - {8'd0, do_pop};
        end
    end

endmodule

// File: rtl/uart_fifo_device.sv
// Memory-mapped UART with TX/RX FIFOs, runtime parity and
// stop-bit config, sticky W1C errors and a registered irq.
module uart_fifo_device
    import uart_fifo_device_pkg::*;
#(
    parameter logic [15:0] DEVICE_ID       = 16'h0,
    parameter logic [7:0]  DEVICE_TYPE     = 8'h4,
    parameter int          TX_DEPTH        = 16,
    parameter int          RX_DEPTH        = 16,
    parameter logic [15:0] DEFAULT_DIVIDER = 16'h446
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        write_enable,
    input  logic        control,
    input  logic [7:0]  address,
    input  logic [15:0] data_in,
    input  logic        rx,
    output logic [15:0] data_out,
    output logic        tx,
    output logic        irq
);

    logic [3:0]  addr;
    logic        reg_wr;
    logic        wr_div;
    logic        wr_tx;
    logic        wr_rxpop;
    logic        wr_cfg;
    logic        wr_err;

    logic [15:0] divider;
    logic [5:0]  cfg;
    logic [3:0]  err;
    logic [3:0]  err_set;
    logic [3:0]  err_clr;

    logic [7:0]  tx_head;
    logic        tx_full;
    logic        tx_empty;
    logic [8:0]  tx_count;
    logic        tx_pop;

    logic        rx_push;
    logic [9:0]  rx_push_data;
    logic [9:0]  rx_head;
    logic        rx_full;
    logic        rx_empty;
    logic [8:0]  rx_count;

    tx_state_t   tx_state;
    tx_state_t   tx_state_n;
    logic [15:0] tx_cnt;
    logic [15:0] tx_cnt_n;
    logic [2:0]  tx_bit;
    logic [2:0]  tx_bit_n;
    logic [7:0]  tx_sh;
    logic [7:0]  tx_sh_n;
    logic [15:0] tx_div;
    logic [15:0] tx_div_n;
    logic [1:0]  tx_mode;
    logic [1:0]  tx_mode_n;
    logic        tx_two;
    logic        tx_two_n;
    logic        tx_tick;
    logic        tx_load;
    logic        tx_line_n;
    logic        tx_q;
    logic        tx_busy;

    logic [1:0]  rx_sync;
    logic        rx_s;
    rx_state_t   rx_state;
    rx_state_t   rx_state_n;
    logic [15:0] rx_cnt;
    logic [15:0] rx_cnt_n;
    logic [2:0]  rx_bit;
    logic [2:0]  rx_bit_n;
    logic [7:0]  rx_sh;
    logic [7:0]  rx_sh_n;
    logic [15:0] rx_div;
    logic [15:0] rx_div_n;
    logic [1:0]  rx_mode;
    logic [1:0]  rx_mode_n;
    logic        rx_perr;
    logic        rx_perr_n;
    logic        rx_tick;
    logic        rx_half_tick;

    logic        irq_n;
    logic        unused_bits;

    assign addr     = address[3:0];
    assign reg_wr   = control & write_enable;
    assign wr_div   = reg_wr && (addr == REG_DIV);
    assign wr_tx    = reg_wr && (addr == REG_TXDATA);
    assign wr_rxpop = reg_wr && (addr == REG_RXDATA);
    assign wr_cfg   = reg_wr && (addr == REG_CONFIG);
    assign wr_err   = reg_wr && (addr == REG_ERR);

    assign unused_bits = ^{address[7:4], tx_count[8], rx_count[8]};

    uart_sync_fifo #(
        .WIDTH(8),
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (wr_tx),
        .push_data(data_in[7:0]),
        .pop      (tx_pop),
        .head     (tx_head),
        .full     (tx_full),
        .empty    (tx_empty),
        .count    (tx_count)
    );

    uart_sync_fifo #(
        .WIDTH(10),
        .DEPTH(RX_DEPTH)
    ) u_rx_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (rx_push),
        .push_data(rx_push_data),
        .pop      (wr_rxpop),
        .head     (rx_head),
        .full     (rx_full),
        .empty    (rx_empty),
        .count    (rx_count)
    );

    assign err_set[ERR_TX_OVF] = wr_tx & tx_full;
    assign err_set[ERR_RX_OVR] = rx_push & rx_full;
    assign err_set[ERR_PARITY] = rx_push & rx_push_data[9];
    assign err_set[ERR_FRAME]  = rx_push & rx_push_data[8];
    assign err_clr = wr_err ? data_in[3:0] : 4'h0;

    // Software-visible registers; a set wins over a W1C clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            divider <= DEFAULT_DIVIDER;
            cfg     <= 6'h0;
            err     <= 4'h0;
        end else begin
            if (wr_div) begin
                divider <= (data_in < 16'd2) ? 16'd2 : data_in;
            end
            if (wr_cfg) begin
                cfg <= data_in[5:0];
            end
            err <= (err & ~err_clr) | err_set;
        end
    end

    // TX state, frame settings and registered serial line.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_sh    <= 8'h0;
            tx_div   <= DEFAULT_DIVIDER;
            tx_mode  <= PAR_NONE;
            tx_two   <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx_div   <= tx_div_n;
            tx_mode  <= tx_mode_n;
            tx_two   <= tx_two_n;
            tx_q     <= tx_line_n;
        end
    end

    // TX next state; a new frame loads straight from the FIFO head.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 16'd1;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_div_n   = tx_div;
        tx_mode_n  = tx_mode;
        tx_two_n   = tx_two;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        tx_line_n  = 1'b1;
        tx_tick    = (tx_cnt == tx_div - 16'd1);
        unique case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = 16'd0;
                tx_load  = ~tx_empty;
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = 16'd0;
                    tx_bit_n   = 3'd0;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_cnt_n = 16'd0;
                    tx_bit_n = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = parity_on(tx_mode) ?
                                     TX_PARITY : TX_STOP1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_tick) begin
                    tx_state_n = TX_STOP1;
                    tx_cnt_n   = 16'd0;
                end
            end
            TX_STOP1: begin
                if (tx_tick) begin
                    tx_cnt_n = 16'd0;
                    if (tx_two) begin
                        tx_state_n = TX_STOP2;
                    end else begin
                        tx_state_n = TX_IDLE;
                        tx_load    = ~tx_empty;
                    end
                end
            end
            TX_STOP2: begin
                if (tx_tick) begin
                    tx_cnt_n   = 16'd0;
                    tx_state_n = TX_IDLE;
                    tx_load    = ~tx_empty;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
            end
        endcase
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_n = TX_START;
            tx_cnt_n   = 16'd0;
            tx_sh_n    = tx_head;
            tx_div_n   = divider;
            tx_mode_n  = cfg[1:0];
            tx_two_n   = cfg[CFG_TWO_STOP];
        end
        case (tx_state_n)
            TX_START:  tx_line_n = 1'b0;
            TX_DATA:   tx_line_n = tx_sh_n[tx_bit_n];
            TX_PARITY: tx_line_n = parity_bit(tx_mode_n, tx_sh_n);
            default:   tx_line_n = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = ~tx_empty | (tx_state != TX_IDLE);

    // Two-flop synchronizer for the asynchronous rx line.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx};
        end
    end

    assign rx_s = rx_sync[1];

    // RX state and frame settings.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_sh    <= 8'h0;
            rx_div   <= DEFAULT_DIVIDER;
            rx_mode  <= PAR_NONE;
            rx_perr  <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_sh    <= rx_sh_n;
            rx_div   <= rx_div_n;
            rx_mode  <= rx_mode_n;
            rx_perr  <= rx_perr_n;
        end
    end

    // RX next state; the entry is pushed at the first stop sample.
    always_comb begin
        rx_state_n   = rx_state;
        rx_cnt_n     = rx_cnt + 16'd1;
        rx_bit_n     = rx_bit;
        rx_sh_n      = rx_sh;
        rx_div_n     = rx_div;
        rx_mode_n    = rx_mode;
        rx_perr_n    = rx_perr;
        rx_push      = 1'b0;
        rx_push_data = {rx_perr, ~rx_s, rx_sh};
        rx_tick      = (rx_cnt == rx_div - 16'd1);
        rx_half_tick = (rx_cnt == (rx_div >> 1) - 16'd1);
        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = 16'd0;
                if (!rx_s) begin
                    rx_state_n = RX_START;
                    rx_div_n   = divider;
                    rx_mode_n  = cfg[1:0];
                    rx_perr_n  = 1'b0;
                end
            end
            RX_START: begin
                if (rx_half_tick) begin
                    rx_cnt_n   = 16'd0;
                    rx_bit_n   = 3'd0;
                    rx_state_n = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_cnt_n = 16'd0;
                    rx_sh_n  = {rx_s, rx_sh[7:1]};
                    rx_bit_n = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
                        rx_state_n = parity_on(rx_mode) ?
                                     RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_tick) begin
                    rx_cnt_n   = 16'd0;
                    rx_perr_n  = rx_s != parity_bit(rx_mode, rx_sh);
                    rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_cnt_n   = 16'd0;
                    rx_push    = 1'b1;
                    rx_state_n = rx_s ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                rx_cnt_n = 16'd0;
                if (rx_s) begin
                    rx_state_n = RX_IDLE;
                end
            end
            default: begin
                rx_state_n = RX_IDLE;
            end
        endcase
    end

    assign irq_n = (cfg[CFG_IRQ_RX] & ~rx_empty)
                 | (cfg[CFG_IRQ_TX] & ~tx_busy)
                 | (cfg[CFG_IRQ_ERR] & (|err));

    // Interrupt is registered, so it trails its cause by a cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_n;
        end
    end

    // Combinational register read mux.
    always_comb begin
        data_out = 16'h0;
        if (control) begin
            case (addr)
                REG_ID:     data_out = DEVICE_ID;
                REG_INFO:   data_out = {GENERATION, |err, tx_busy,
                                        ~rx_empty, ~tx_full,
                                        DEVICE_TYPE};
                REG_DIV:    data_out = divider;
                REG_TXDATA: data_out = {8'h0, tx_count[7:0]};
                REG_RXDATA: data_out = rx_empty ? 16'h0 :
                                       {6'h0, rx_head};
                REG_CONFIG: data_out = {10'h0, cfg};
                REG_ERR:    data_out = {12'h0, err};
                REG_COUNTS: data_out = {rx_count[7:0], tx_count[7:0]};
                default:    data_out = 16'h0;
            endcase
        end
    end

endmodule
